// File: rtl/mux_share_pkg.sv
// Shared types for the three-way mux-sharing arbiter: owner/state encodings
// and the owner-to-mux-select mapping used by the top level.
package mux_share_pkg;

    typedef enum logic [1:0] {
        OWN_A = 2'd0,
        OWN_B = 2'd1,
        OWN_C = 2'd2
    } owner_e;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } state_e;

    typedef struct packed {
        logic selection_2;
        logic selection_1;
    } sel_t;

    // Level 1 chooses A/B, level 2 chooses level-1/C.
    function automatic sel_t owner_to_sel(input owner_e owner);
        sel_t s;
        s = '0;
        case (owner)
            OWN_A:   s = '{selection_2: 1'b0, selection_1: 1'b0};
            OWN_B:   s = '{selection_2: 1'b0, selection_1: 1'b1};
            default: s = '{selection_2: 1'b1, selection_1: 1'b0};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mux_share_arbiter_rr_priority_pick.sv
// Round-robin pick: first requester strictly after last_owner in A->B->C->A
// order; last_owner itself is the final candidate of the rotation.
module rr_priority_pick
    import mux_share_pkg::*;
(
    input  logic [2:0] req,
    input  owner_e     last_owner,
    output owner_e     next_owner,
    output logic       any_req
);

    always_comb begin
        next_owner = last_owner;
        any_req    = |req;
        case (last_owner)
            OWN_A: begin
                if (req[1])      next_owner = OWN_B;
                else if (req[2]) next_owner = OWN_C;
                else if (req[0]) next_owner = OWN_A;
            end
            OWN_B: begin
                if (req[2])      next_owner = OWN_C;
                else if (req[0]) next_owner = OWN_A;
                else if (req[1]) next_owner = OWN_B;
            end
            default: begin
                if (req[0])      next_owner = OWN_A;
                else if (req[1]) next_owner = OWN_B;
                else if (req[2]) next_owner = OWN_C;
            end
        endcase
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning the select lines of a cascaded 2:1/2:1 mux that
// shares one valid/ready output among requesters A, B and C, with burst limit.
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             req_c,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             gnt_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             selection_1,
    output logic             selection_2
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

    state_e        state;
    owner_e        owner;
    owner_e        last_owner;
    owner_e        pick_owner;
    logic          any_req;
    logic          last_valid;
    logic          last_req;
    logic          regrant;
    logic          accept;
    logic [2:0]    req_vec;
    logic [CW-1:0] burst_cnt;

    assign req_vec = {req_c, req_b, req_a};

    rr_priority_pick u_pick (
        .req        (req_vec),
        .last_owner (last_owner),
        .next_owner (pick_owner),
        .any_req    (any_req)
    );

    always_comb begin
        last_req = 1'b0;
        case (last_owner)
            OWN_A:   last_req = req_a;
            OWN_B:   last_req = req_b;
            default: last_req = req_c;
        endcase
    end

    // last_valid blocks a re-grant before any word has moved, so the reset
    // value of last_owner (C) only seeds the rotation and A goes first.
    assign regrant = last_valid && last_req && (burst_cnt < BURST_MAX);
    assign accept  = out_valid && out_ready;

    assign gnt_a = accept && (owner == OWN_A);
    assign gnt_b = accept && (owner == OWN_B);
    assign gnt_c = accept && (owner == OWN_C);

    assign out_data = selection_2 ? data_c : (selection_1 ? data_b : data_a);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB;
            out_valid   <= 1'b0;
            owner       <= OWN_A;
            last_owner  <= OWN_C;
            last_valid  <= 1'b0;
            burst_cnt   <= '0;
            selection_1 <= 1'b0;
            selection_2 <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (regrant) begin
                        owner                      <= last_owner;
                        {selection_2, selection_1} <= owner_to_sel(last_owner);
                        state                      <= XFER;
                        out_valid                  <= 1'b1;
                    end else if (any_req) begin
                        owner                      <= pick_owner;
                        {selection_2, selection_1} <= owner_to_sel(pick_owner);
                        burst_cnt                  <= '0;
                        state                      <= XFER;
                        out_valid                  <= 1'b1;
                    end
                end
                default: begin
                    // Word is held until accepted even if the owner drops req.
                    if (out_ready) begin
                        state      <= ARB;
                        out_valid  <= 1'b0;
                        last_owner <= owner;
                        last_valid <= 1'b1;
                        if (burst_cnt < BURST_MAX)
                            burst_cnt <= burst_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Scoreboard bench for mux_share_arbiter: directed stimulus pushes expected
// (owner, word) pairs; a monitor checks every accepted transfer and gnt quietness.
module tb_mux_share_arbiter;

    typedef struct {
        int         own;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] req_v;
    logic [7:0] dat_v [3];
    logic       gnt_a, gnt_b, gnt_c;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       selection_1, selection_2;
    logic [2:0] gnt_v;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    assign gnt_v = {gnt_c, gnt_b, gnt_a};

    mux_share_arbiter #(.WIDTH(8), .MAX_BURST(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_a       (req_v[0]),
        .req_b       (req_v[1]),
        .req_c       (req_v[2]),
        .data_a      (dat_v[0]),
        .data_b      (dat_v[1]),
        .data_c      (dat_v[2]),
        .gnt_a       (gnt_a),
        .gnt_b       (gnt_b),
        .gnt_c       (gnt_c),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .selection_1 (selection_1),
        .selection_2 (selection_2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic push(input int own, input logic [7:0] data);
        exp_t e;
        e.own  = own;
        e.data = data;
        sb.push_back(e);
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_accept", 32'(gnt_v), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("gnt_onehot", 32'(gnt_v), 32'(3'b001 << e.own));
                    chk("selects", 32'({selection_2, selection_1}),
                        32'({e.own == 2, e.own == 1}));
                end
            end else begin
                chk("gnt_idle", 32'(gnt_v), 32'd0);
            end
        end
    end

    task automatic wait_gnt(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_v[idx] !== 1'b1 && n < 100);
        if (gnt_v[idx] !== 1'b1) chk("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid !== 1'b1 && n < 100);
        if (out_valid !== 1'b1) chk("valid_timeout", 32'd0, 32'd1);
    endtask

    // Requester model: supplies n consecutive words, changing only after its gnt.
    task automatic requester(input int idx, input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) begin
            req_v[idx] = 1'b1;
            dat_v[idx] = base + 8'(k);
            wait_gnt(idx);
            @(posedge clk);
            #1;
        end
        req_v[idx] = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        req_v     = 3'b000;
        dat_v[0]  = 8'h00;
        dat_v[1]  = 8'h00;
        dat_v[2]  = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'({selection_2, selection_1}), 32'd0);
        chk("rst_gnt", 32'(gnt_v), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Contention: A first after reset, then bursts of two in rotation.
        out_ready = 1'b1;
        push(0, 8'hA0); push(0, 8'hA1);
        push(1, 8'hB0); push(1, 8'hB1);
        push(2, 8'hC0); push(2, 8'hC1);
        push(0, 8'hA2); push(0, 8'hA3);
        fork
            requester(0, 4, 8'hA0);
            requester(1, 2, 8'hB0);
            requester(2, 2, 8'hC0);
        join
        @(negedge clk);
        chk("rr_drain", 32'(sb.size()), 32'd0);

        // Reset in the middle of a held transfer drops the word.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_v[0]  = 1'b1;
        dat_v[0]  = 8'h11;
        wait_valid();
        #2;
        reset    = 1'b1;
        req_v[0] = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_sel", 32'({selection_2, selection_1}), 32'd0);
        chk("midrst_gnt", 32'(gnt_v), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // B alone after reset.
        out_ready = 1'b1;
        push(1, 8'h5B);
        requester(1, 1, 8'h5B);
        chk("b_alone_sel", 32'({selection_2, selection_1}), 32'b01);

        // Single requester latency and idle gap.
        req_v[0] = 1'b1;
        dat_v[0] = 8'h3C;
        push(0, 8'h3C);
        @(negedge clk);
        chk("lat_arb", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_xfer", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'h3C);
        @(posedge clk);
        #1 req_v[0] = 1'b0;
        @(negedge clk);
        chk("idle_gap", 32'(out_valid), 32'd0);

        // Back-pressure on C for five cycles.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_v[2]  = 1'b1;
        dat_v[2]  = 8'hA5;
        push(2, 8'hA5);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'hA5);
            chk("bp_sel2", 32'(selection_2), 32'd1);
            chk("bp_gnt", 32'(gnt_c), 32'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_gnt", 32'(gnt_c), 32'd1);
        @(posedge clk);
        #1 req_v[2] = 1'b0;

        // Burst cut short: A takes one, C next, C's burst restarts so C keeps
        // priority over B for its second word.
        push(0, 8'h11);
        push(2, 8'h33);
        push(2, 8'h34);
        push(1, 8'h77);
        requester(0, 1, 8'h11);
        requester(2, 1, 8'h33);
        fork
            requester(2, 1, 8'h34);
            requester(1, 1, 8'h77);
        join
        @(negedge clk);
        chk("burst_drain", 32'(sb.size()), 32'd0);

        // Owner drops req while its word is held.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req_v[1]  = 1'b1;
        dat_v[1]  = 8'h5E;
        push(1, 8'h5E);
        wait_valid();
        #1 req_v[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("viol_valid", 32'(out_valid), 32'd1);
            chk("viol_data", 32'(out_data), 32'h5E);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("viol_gnt", 32'(gnt_b), 32'd1);
        @(negedge clk);
        chk("viol_after_valid", 32'(out_valid), 32'd0);
        chk("viol_after_gnt", 32'(gnt_v), 32'd0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
